// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module  : io_pkg
// Purpose : Shared definitions for the switch/button input controller:
//           LSU register addresses and the debounce channel state type.
// Ports   : none (package)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
package io_pkg;

  // LSU register map (byte addresses; only bits [3:2] are decoded)
  localparam logic [3:0] IO_SW_ADDR    = 4'h0;
  localparam logic [3:0] IO_BTN_ADDR   = 4'h4;
  localparam logic [3:0] IO_PRESS_ADDR = 4'h8;
  localparam logic [3:0] IO_STAT_ADDR  = 4'hC;

  typedef enum logic {
    DB_IDLE   = 1'b0,
    DB_SETTLE = 1'b1
  } db_state_e;

  // Word index of a byte address
  function automatic logic [1:0] word_sel(input logic [3:0] addr);
    return addr[3:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_debounce.sv
`default_nettype none
// ============================================================================
// Module  : io_debounce
// Purpose : Multi-stage synchroniser followed by a whole-word debouncer.
//           A new synchronised value must be seen DEBOUNCE_CYCLES+1
//           consecutive times before it is committed to o_stable.
// Ports   : i_clk      - clock
//           i_rst_n    - asynchronous active-low reset
//           i_din      - raw asynchronous input word
//           o_stable   - debounced (committed) word
//           o_settling - 1 while a candidate word is being qualified
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
module io_debounce
  import io_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_stable,
  output logic             o_settling
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  w_s;
  db_state_e                         r_state;
  logic [WIDTH-1:0]                  r_cand;
  logic [WIDTH-1:0]                  r_stable;
  logic [CNT_W-1:0]                  r_cnt;

  // Stage 0 captures the pin; each later stage copies its predecessor.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= DB_IDLE;
      r_cand   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        DB_IDLE: begin
          if (w_s != r_stable) begin
            r_cand  <= w_s;
            r_cnt   <= C_CNT_ONE;
            r_state <= DB_SETTLE;
          end
        end
        DB_SETTLE: begin
          if (w_s != r_cand) begin
            if (w_s == r_stable) begin
              // Input bounced back to the committed value
              r_cnt   <= '0;
              r_state <= DB_IDLE;
            end else begin
              // A different new value: qualify it from scratch
              r_cand <= w_s;
              r_cnt  <= C_CNT_ONE;
            end
          end else if (r_cnt == C_CNT_MAX) begin
            r_stable <= r_cand;
            r_cnt    <= '0;
            r_state  <= DB_IDLE;
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end
      endcase
    end
  end

  assign o_stable   = r_stable;
  assign o_settling = (r_state == DB_SETTLE);

endmodule
`default_nettype wire

// File: rtl/input_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : input_io_ctrl
// Purpose : Switch/button front end for the LSU. Debounces both input words,
//           latches button rising edges into sticky W1C press flags and
//           serves four registers over a 1-cycle-latency read port.
// Ports   : i_clk, i_rst_n       - clock, asynchronous active-low reset
//           i_io_sw, i_io_btn    - raw asynchronous pins (32 bits each)
//           i_rd_en, i_wr_en     - LSU read / write strobes
//           i_addr               - byte address, bits [3:2] decoded
//           i_wdata              - write data (W1C clear mask for 0x8)
//           o_rdata, o_rvalid    - registered read data and its qualifier
//           o_irq                - |press flags (only with IO_IRQ_EN)
// Config  : IO_IRQ_EN - when defined adds the o_irq port and its register
// Revision: 1.0 - initial release
// ============================================================================
module input_io_ctrl
  import io_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_io_sw,
  input  logic [31:0] i_io_btn,
  input  logic        i_rd_en,
  input  logic        i_wr_en,
  input  logic [3:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_rvalid
`ifdef IO_IRQ_EN
  ,
  output logic        o_irq
`endif
);

  logic [31:0] w_sw_stable;
  logic [31:0] w_btn_stable;
  logic        w_sw_settling;
  logic        w_btn_settling;
  logic [31:0] r_btn_prev;
  logic [31:0] r_press;
  logic [31:0] w_rise;
  logic        w_press_wr;
  logic [31:0] w_rd_mux;
  logic [31:0] r_rdata;
  logic        r_rvalid;
  logic        w_unused_addr;

  // Byte-lane bits are not decoded
  assign w_unused_addr = ^i_addr[1:0];

  io_debounce #(
    .WIDTH          (32),
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_sw_db (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_din     (i_io_sw),
    .o_stable  (w_sw_stable),
    .o_settling(w_sw_settling)
  );

  io_debounce #(
    .WIDTH          (32),
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn_db (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_din     (i_io_btn),
    .o_stable  (w_btn_stable),
    .o_settling(w_btn_settling)
  );

  assign w_rise     = w_btn_stable & ~r_btn_prev;
  assign w_press_wr = i_wr_en && (word_sel(i_addr) == word_sel(IO_PRESS_ADDR));

  // OR-ing the rise after the clear mask lets a same-cycle press win
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_btn_prev <= '0;
      r_press    <= '0;
    end else begin
      r_btn_prev <= w_btn_stable;
      if (w_press_wr) begin
        r_press <= (r_press & ~i_wdata) | w_rise;
      end else begin
        r_press <= r_press | w_rise;
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (word_sel(i_addr))
      word_sel(IO_SW_ADDR):    w_rd_mux = w_sw_stable;
      word_sel(IO_BTN_ADDR):   w_rd_mux = w_btn_stable;
      word_sel(IO_PRESS_ADDR): w_rd_mux = r_press;
      word_sel(IO_STAT_ADDR):  w_rd_mux = {30'b0, w_btn_settling, w_sw_settling};
      default:                 w_rd_mux = '0;
    endcase
  end

  // Read data is captured before any same-cycle W1C takes effect
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= i_rd_en;
      if (i_rd_en) begin
        r_rdata <= w_rd_mux;
      end
    end
  end

  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;

`ifdef IO_IRQ_EN
  logic r_irq;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |r_press;
    end
  end

  assign o_irq = r_irq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_input_io_ctrl
// Purpose : Self-checking bench for input_io_ctrl. A cycle-level reference
//           model (sync delay line plus run-length debounce rule) predicts
//           o_rdata / o_rvalid / o_irq every cycle; directed steps add
//           fixed expected values for the documented scenarios.
// Config  : IO_IRQ_EN - also connects and checks o_irq
// Revision: 1.0 - initial release
// ============================================================================
module tb_input_io_ctrl;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] io_sw;
  logic [31:0] io_btn;
  logic        rd_en;
  logic        wr_en;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        irq;

  int tests = 0;
  int fails = 0;

  input_io_ctrl #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_io_sw (io_sw),
    .i_io_btn(io_btn),
    .i_rd_en (rd_en),
    .i_wr_en (wr_en),
    .i_addr  (addr),
    .i_wdata (wdata),
    .o_rdata (rdata),
    .o_rvalid(rvalid)
`ifdef IO_IRQ_EN
    ,
    .o_irq   (irq)
`endif
  );

`ifndef IO_IRQ_EN
  assign irq = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_pipe_sw [SYNC];
  logic [31:0] m_pipe_btn[SYNC];
  logic [31:0] m_sw_stable, m_btn_stable;
  logic [31:0] m_sw_rv, m_btn_rv;
  int          m_sw_rl, m_btn_rl;
  logic        m_sw_settling, m_btn_settling;
  logic [31:0] m_btn_prev, m_press, m_rdata;
  logic        m_rvalid, m_irq;

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) begin
      m_pipe_sw[i]  = '0;
      m_pipe_btn[i] = '0;
    end
    m_sw_stable = '0; m_btn_stable = '0;
    m_sw_rv = '0; m_btn_rv = '0; m_sw_rl = 0; m_btn_rl = 0;
    m_sw_settling = 1'b0; m_btn_settling = 1'b0;
    m_btn_prev = '0; m_press = '0; m_rdata = '0;
    m_rvalid = 1'b0; m_irq = 1'b0;
  endtask

  // A value commits once it has been seen DEB+1 samples in a row
  task automatic chan_update(input logic [31:0] s, inout logic [31:0] stable,
                             inout logic [31:0] rv, inout int rl, output logic settling);
    if (rl > 0 && s == rv) rl++;
    else begin
      rv = s;
      rl = 1;
    end
    if (s != stable && rl >= DEB + 1) stable = s;
    settling = (s != stable);
  endtask

  task automatic model_edge();
    logic [31:0] rd_val, rise, press_n, s_sw, s_btn;
    logic        irq_n;
    case (addr[3:2])
      2'd0:    rd_val = m_sw_stable;
      2'd1:    rd_val = m_btn_stable;
      2'd2:    rd_val = m_press;
      default: rd_val = {30'b0, m_btn_settling, m_sw_settling};
    endcase
    irq_n   = |m_press;
    rise    = m_btn_stable & ~m_btn_prev;
    press_n = (wr_en && addr[3:2] == 2'd2) ? ((m_press & ~wdata) | rise) : (m_press | rise);
    m_btn_prev = m_btn_stable;
    s_sw  = m_pipe_sw[SYNC-1];
    s_btn = m_pipe_btn[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) begin
      m_pipe_sw[i]  = m_pipe_sw[i-1];
      m_pipe_btn[i] = m_pipe_btn[i-1];
    end
    m_pipe_sw[0]  = io_sw;
    m_pipe_btn[0] = io_btn;
    chan_update(s_sw, m_sw_stable, m_sw_rv, m_sw_rl, m_sw_settling);
    chan_update(s_btn, m_btn_stable, m_btn_rv, m_btn_rl, m_btn_settling);
    m_press  = press_n;
    m_irq    = irq_n;
    m_rvalid = rd_en;
    if (rd_en) m_rdata = rd_val;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("rvalid", {31'b0, rvalid}, {31'b0, m_rvalid});
    check("rdata", rdata, m_rdata);
`ifdef IO_IRQ_EN
    check("irq", {31'b0, irq}, {31'b0, m_irq});
`endif
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    check_outputs();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rd(input logic [3:0] a);
    rd_en = 1'b1;
    addr  = a;
    step();
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    step();
    wr_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic saw_settle;
    logic found;
    int   r;

    rst_n = 1'b0; io_sw = 32'hA5A5_A5A5; io_btn = '0;
    rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
    model_reset();
    #1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_rvalid", {31'b0, rvalid}, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    steps(3);
    rst_n = 1'b1;

    // 1: switch word held through reset commits after 7 edges
    rd_en = 1'b1; addr = 4'h0;
    steps(7);
    check("t1_edge7_read", rdata, 32'h0);
    step();
    check("t1_edge8_read", rdata, 32'hA5A5_A5A5);
    rd_en = 1'b0;

    // 2: 2-cycle glitch is rejected, status shows settling meanwhile
    io_sw = '0;
    steps(10);
    io_sw = 32'h1;
    rd_en = 1'b1; addr = 4'hC;
    saw_settle = 1'b0;
    step();
    if (rdata[0]) saw_settle = 1'b1;
    step();
    if (rdata[0]) saw_settle = 1'b1;
    io_sw = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rdata[0]) saw_settle = 1'b1;
    end
    check("t2_saw_settling", {31'b0, saw_settle}, 32'h1);
    steps(4);
    check("t2_status_idle", rdata, 32'h0);
    rd_en = 1'b0;
    rd(4'h0);
    check("t2_sw_stable", rdata, 32'h0);

    // 3: button word settles, all its set bits become press flags
    io_btn = 32'hB5B5_B5B5;
    steps(12);
    rd(4'h8);
    check("t3_press", rdata, 32'hB5B5_B5B5);
    rd(4'h4);
    check("t3_btn_stable", rdata, 32'hB5B5_B5B5);
`ifdef IO_IRQ_EN
    check("t3_irq", {31'b0, irq}, 32'h1);
`endif

    // 4: partial W1C clear
    wr(4'h8, 32'h0000_00FF);
    rd(4'h8);
    check("t4_press", rdata, 32'hB5B5_B500);
    step();
`ifdef IO_IRQ_EN
    check("t4_irq", {31'b0, irq}, 32'h1);
`endif
    wr(4'h0, 32'hFFFF_FFFF);
    wr(4'hC, 32'hFFFF_FFFF);
    rd(4'h8);
    check("t4_ignored_writes", rdata, 32'hB5B5_B500);

    // 5: full clear landing on the same edge as a new bit0 rise
    io_btn = 32'hB5B5_B5B4;
    steps(10);
    io_btn = 32'hB5B5_B5B5;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (m_btn_stable[0] && !m_btn_prev[0]) found = 1'b1;
    end
    if (!found) begin
      tests++;
      fails++;
      $error("FAIL t5_rise_timeout observed=0 expected=1");
    end
    wr(4'h8, 32'hFFFF_FFFF);
    rd(4'h8);
    check("t5_set_wins", rdata, 32'h0000_0001);

    // read and clear in the same cycle returns the pre-clear value
    rd_en = 1'b1; wr_en = 1'b1; addr = 4'h8; wdata = 32'hFFFF_FFFF;
    step();
    rd_en = 1'b0; wr_en = 1'b0;
    check("rw_same_cycle", rdata, 32'h0000_0001);
    rd(4'h8);
    check("rw_after_clear", rdata, 32'h0);

    // 6: reset in the middle of a settle
    io_sw = '0;
    steps(10);
    io_sw = 32'hFF;
    steps(4);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_rst_rdata", rdata, 32'h0);
    check("t6_rst_rvalid", {31'b0, rvalid}, 32'h0);
    check("t6_rst_irq", {31'b0, irq}, 32'h0);
    steps(2);
    rst_n = 1'b1;
    rd_en = 1'b1; addr = 4'h0;
    steps(7);
    check("t6_edge7_read", rdata, 32'h0);
    step();
    check("t6_edge8_read", rdata, 32'h0000_00FF);
    rd_en = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0) io_sw = $urandom;
      else if (r == 1) io_btn = $urandom;
      else if (r == 2) io_btn = io_btn ^ (32'h1 << $urandom_range(0, 31));
      else if (r == 3) io_sw = io_sw ^ (32'h1 << $urandom_range(0, 31));
      rd_en = 1'($urandom_range(0, 1));
      wr_en = ($urandom_range(0, 3) == 0);
      addr  = 4'($urandom_range(0, 15));
      wdata = $urandom;
      step();
    end
    rd_en = 1'b0; wr_en = 1'b0;
    steps(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
